// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule constants, mode encodings, xtime and S-box helpers
package aes_pkg;

  localparam logic [1:0] MODE_AES128  = 2'd0;
  localparam logic [1:0] MODE_AES192  = 2'd1;
  localparam logic [1:0] MODE_AES256  = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam logic [3:0] NK_AES128 = 4'd4;
  localparam logic [3:0] NK_AES192 = 4'd6;
  localparam logic [3:0] NK_AES256 = 4'd8;

  localparam logic [3:0] NR_AES128 = 4'd10;
  localparam logic [3:0] NR_AES192 = 4'd12;
  localparam logic [3:0] NR_AES256 = 4'd14;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX_TABLE[idx -: 8];
  endfunction

  // Returns 0 for the illegal encoding so callers can test legality directly.
  function automatic logic [3:0] nk_of_mode(input logic [1:0] mode);
    case (mode)
      MODE_AES128: return NK_AES128;
      MODE_AES192: return NK_AES192;
      MODE_AES256: return NK_AES256;
      default:     return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// rtl/aes_key_expand_seq_if.sv - request, status and round-key read port of the key expander
interface aes_key_expand_seq_if #(
  parameter int MAX_NK = 8
);
  logic                  start;
  logic [1:0]            key_mode;
  logic [32*MAX_NK-1:0]  key;
  logic                  busy;
  logic                  done;
  logic                  keys_valid;
  logic                  err;
  logic [3:0]            rk_idx;
  logic [127:0]          rk;

  modport master (
    output start, key_mode, key, rk_idx,
    input  busy, done, keys_valid, err, rk
  );

  modport slave (
    input  start, key_mode, key, rk_idx,
    output busy, done, keys_valid, err, rk
  );
endinterface

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - four parallel S-box lookups on a 32-bit schedule word
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub_word
);
  assign sub_word[31:24] = sbox(word[31:24]);
  assign sub_word[23:16] = sbox(word[23:16]);
  assign sub_word[15:8]  = sbox(word[15:8]);
  assign sub_word[7:0]   = sbox(word[7:0]);
endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-128/192/256 key schedule, one word per cycle,
// with random-access 128-bit round-key reads from the word store
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input logic                 clk,
  input logic                 reset,
  aes_key_expand_seq_if.slave bus
);
  localparam int NUM_WORDS = 4 * (MAX_NK + 7);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]  state_q;
  logic [3:0]  nk_q;
  logic [3:0]  nr_q;
  logic [5:0]  i_q;
  logic [5:0]  last_q;
  logic [2:0]  j_q;
  logic [7:0]  rcon_q;
  logic        keys_valid_q;
  logic        err_q;
  logic [31:0] w_q [NUM_WORDS];

  logic [3:0]   req_nk;
  logic         req_legal;
  logic         accept;
  logic         reject;
  logic [5:0]   idx_prev;
  logic [5:0]   idx_back;
  logic [31:0]  w_prev;
  logic [31:0]  w_back;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp;
  logic [31:0]  w_new;
  logic [5:0]   rk_base;
  logic [127:0] rk_word;

  always_comb begin
    req_nk    = nk_of_mode(bus.key_mode);
    req_legal = (req_nk != 4'd0) && (int'(req_nk) <= MAX_NK);
  end

  assign accept = (state_q == ST_IDLE) && bus.start && req_legal;
  assign reject = (state_q == ST_IDLE) && bus.start && !req_legal;

  assign idx_prev = i_q - 6'd1;
  assign idx_back = i_q - {2'b00, nk_q};
  assign w_prev   = w_q[idx_prev];
  assign w_back   = w_q[idx_back];

  // One S-box bank serves both the rotated (j==0) and the AES-256 mid-key (j==4) cases.
  assign sub_in = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .word     (sub_in),
    .sub_word (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (j_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == NK_AES256 && j_q == 3'd4)
      temp = sub_out;
  end

  assign w_new = w_back ^ temp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      nk_q         <= 4'd0;
      nr_q         <= 4'd0;
      i_q          <= 6'd0;
      last_q       <= 6'd0;
      j_q          <= 3'd0;
      rcon_q       <= 8'h01;
      keys_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= reject;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q      <= ST_EXPAND;
            nk_q         <= req_nk;
            nr_q         <= req_nk + 4'd6;
            i_q          <= {2'b00, req_nk};
            last_q       <= {req_nk + 4'd7, 2'b00} - 6'd1;
            j_q          <= 3'd0;
            rcon_q       <= 8'h01;
            keys_valid_q <= 1'b0;
          end
        end
        ST_EXPAND: begin
          i_q <= i_q + 6'd1;
          j_q <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
          if (j_q == 3'd0)
            rcon_q <= xtime(rcon_q);
          if (i_q == last_q) begin
            state_q      <= ST_DONE;
            keys_valid_q <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Store is not reset: stale contents are hidden by keys_valid.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      for (int k = 0; k < MAX_NK; k++)
        w_q[k] <= bus.key[32*(MAX_NK-k)-1 -: 32];
    end else if (reset && state_q == ST_EXPAND) begin
      w_q[i_q] <= w_new;
    end
  end

  assign rk_base = {bus.rk_idx, 2'b00};

  always_comb begin
    rk_word = '0;
    if (keys_valid_q && bus.rk_idx <= nr_q)
      rk_word = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
  end

  assign bus.rk         = rk_word;
  assign bus.busy       = (state_q == ST_EXPAND);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.keys_valid = keys_valid_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - scoreboard bench for aes_key_expand_seq with FIPS-197 vectors
module tb_aes_key_expand_seq;
  import aes_pkg::*;

  localparam int EV_DONE = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_RK   = 2;

  localparam logic [127:0] M_ALL = '1;
  localparam logic [127:0] M_LO  = 128'hffffffff;

  localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] RK192_12 = 128'h01002202;
  localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK256_14 = 128'h706c631e;

  typedef struct {
    int           kind;
    string        name;
    logic [127:0] value;
    logic [127:0] mask;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rd_req = 1'b0;
  int   cyc = 0;
  int   t_start = 0;
  int   errors = 0;
  int   checks = 0;

  aes_key_expand_seq_if #(.MAX_NK(8)) bus ();
  aes_key_expand_seq #(.MAX_NK(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  aes_key_expand_seq_if #(.MAX_NK(4)) bus4 ();
  aes_key_expand_seq #(.MAX_NK(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input int kind, input string name, input logic [127:0] value,
                          input logic [127:0] mask);
    exp_t e;
    e.kind = kind;
    e.name = name;
    e.value = value;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [127:0] act);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d value %h expected no event", kind, act);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      checks++;
      errors++;
      $display("FAIL %s: got event kind %0d expected kind %0d", e.name, kind, e.kind);
    end else begin
      check(e.name, act & e.mask, e.value & e.mask);
    end
  endtask

  // Monitor: done carries latency, err carries busy (must be 0), reads carry rk.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.done) pop_check(EV_DONE, 128'(cyc - t_start));
      if (bus.err)  pop_check(EV_ERR, 128'(bus.busy));
      if (rd_req)   pop_check(EV_RK, bus.rk);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [1:0] mode, input logic [255:0] key, input int exp_lat,
                           input string name);
    bus.key_mode = mode;
    bus.key = key;
    bus.start = 1'b1;
    t_start = cyc;
    if (exp_lat > 0) push_exp(EV_DONE, name, 128'(exp_lat), M_ALL);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 200) begin
      step();
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 expected done=1 within 200 cycles", name);
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, input logic [127:0] value, input logic [127:0] mask,
                         input string name);
    step();
    bus.rk_idx = idx;
    rd_req = 1'b1;
    push_exp(EV_RK, name, value, mask);
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.key_mode = 2'd0;
    bus.key = '0;
    bus.rk_idx = 4'd0;
    bus4.start = 1'b0;
    bus4.key_mode = 2'd0;
    bus4.key = '0;
    bus4.rk_idx = 4'd0;

    repeat (3) step();
    reset = 1'b1;
    step();
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_done", 128'(bus.done), 128'd0);
    check("reset_keys_valid", 128'(bus.keys_valid), 128'd0);
    check("reset_err", 128'(bus.err), 128'd0);
    check("reset_rk", bus.rk, 128'd0);

    // AES-128 with garbage in the unused low half of key
    start_req(MODE_AES128, {K128, 128'hdeadbeefcafef00d0123456789abcdef}, 41, "aes128_latency");
    wait_done("aes128");
    read_rk(4'd0, K128, M_ALL, "aes128_rk0");
    read_rk(4'd1, RK128_1, M_ALL, "aes128_rk1");
    read_rk(4'd10, RK128_10, M_ALL, "aes128_rk10");
    read_rk(4'd11, 128'd0, M_ALL, "aes128_rk11_out_of_range");

    // Illegal mode: err pulse, schedule untouched
    push_exp(EV_ERR, "illegal_err_busy", 128'd0, M_ALL);
    start_req(MODE_ILLEGAL, K256, 0, "illegal");
    repeat (2) step();
    check("illegal_busy", 128'(bus.busy), 128'd0);
    check("illegal_keys_valid", 128'(bus.keys_valid), 128'd1);
    read_rk(4'd10, RK128_10, M_ALL, "illegal_rk10_kept");

    start_req(MODE_AES192, {K192, 64'hffffffffffffffff}, 47, "aes192_latency");
    wait_done("aes192");
    read_rk(4'd1, RK192_1, M_ALL, "aes192_rk1");
    read_rk(4'd12, RK192_12, M_LO, "aes192_w51");
    read_rk(4'd13, 128'd0, M_ALL, "aes192_rk13_out_of_range");

    start_req(MODE_AES256, K256, 53, "aes256_latency");
    wait_done("aes256");
    read_rk(4'd2, RK256_2, M_ALL, "aes256_rk2");
    read_rk(4'd14, RK256_14, M_LO, "aes256_w59");

    // start while busy is ignored
    start_req(MODE_AES128, {K128, 128'd0}, 41, "busy_start_latency");
    repeat (10) step();
    bus.key_mode = MODE_AES256;
    bus.key = K256;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("busy_start");
    read_rk(4'd10, RK128_10, M_ALL, "busy_start_rk10");

    // Back-to-back: start held through DONE (ignored) into the following IDLE cycle
    start_req(MODE_AES256, K256, 53, "b2b_first_latency");
    wait_done("b2b_first");
    bus.key_mode = MODE_AES128;
    bus.key = {K128, 128'd0};
    bus.start = 1'b1;
    step();
    t_start = cyc;
    push_exp(EV_DONE, "b2b_second_latency", 128'd41, M_ALL);
    step();
    bus.start = 1'b0;
    check("b2b_keys_valid_drop", 128'(bus.keys_valid), 128'd0);
    check("b2b_busy", 128'(bus.busy), 128'd1);
    wait_done("b2b_second");
    read_rk(4'd10, RK128_10, M_ALL, "b2b_rk10");
    read_rk(4'd11, 128'd0, M_ALL, "b2b_rk11_out_of_range");

    // Reset in the middle of an AES-256 run, then reset together with start
    start_req(MODE_AES256, K256, 0, "abort");
    repeat (19) step();
    bus.rk_idx = 4'd0;
    reset = 1'b0;
    step();
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_done", 128'(bus.done), 128'd0);
    check("abort_keys_valid", 128'(bus.keys_valid), 128'd0);
    check("abort_rk", bus.rk, 128'd0);
    bus.key_mode = MODE_AES128;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("reset_wins_busy", 128'(bus.busy), 128'd0);
    reset = 1'b1;
    repeat (2) step();
    check("after_reset_busy", 128'(bus.busy), 128'd0);
    start_req(MODE_AES128, {K128, 128'd0}, 41, "restart_latency");
    wait_done("restart");
    read_rk(4'd10, RK128_10, M_ALL, "restart_rk10");

    // MAX_NK=4 instance rejects AES-256 and still runs AES-128
    bus4.key_mode = MODE_AES256;
    bus4.key = K128;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    check("nk4_mode2_err", 128'(bus4.err), 128'd1);
    check("nk4_mode2_busy", 128'(bus4.busy), 128'd0);
    bus4.key_mode = MODE_AES128;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    n = 0;
    while (!bus4.done && n < 200) begin
      step();
      n++;
    end
    check("nk4_done_seen", 128'(bus4.done), 128'd1);
    step();
    bus4.rk_idx = 4'd10;
    #1;
    check("nk4_rk10", bus4.rk, RK128_10);

    repeat (3) step();
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
